stage_sequencer: RTL and testbench

//  Parametrised multi-cycle stage sequencer for the non-pipelined core. Steps an instruction

---
 rtl/stage_sequencer.sv | 117 +++++++++++
 tb/tb_stage_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the non-pipelined core: walks each instruction through
// N_STAGES one-hot stage enables, with stall hold, halt-at-boundary, single-step and a retire counter.
module stage_sequencer #(
  parameter int N_STAGES = 9,
  parameter int CNT_W    = 32,
  localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                step_mode,
  output logic [N_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]    stage_idx,
  output logic                stage_reset_n,
  output logic                busy,
  output logic                halted,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(N_STAGES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  stage_idx_q, stage_idx_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic              instr_done_q, instr_done_d;
  logic              halt_pend_q, halt_pend_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      stage_idx_q   <= '0;
      instr_count_q <= '0;
      instr_done_q  <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_idx_q   <= stage_idx_d;
      instr_count_q <= instr_count_d;
      instr_done_q  <= instr_done_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stage_idx_d   = stage_idx_q;
    instr_count_d = instr_count_q;
    instr_done_d  = 1'b0;
    halt_pend_d   = halt_pend_q;
    case (state_q)
      ST_INIT: begin
        state_d     = ST_IDLE;
        stage_idx_d = '0;
      end
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (start) begin
          state_d     = ST_RUN;
          stage_idx_d = '0;
        end
      end
      ST_RUN: begin
        // A halt seen mid-instruction is remembered so the instruction still retires.
        if (halt) halt_pend_d = 1'b1;
        if (!stall) begin
          if (stage_idx_q == LAST_STAGE) begin
            stage_idx_d   = '0;
            instr_count_d = instr_count_q + CNT_W'(1);
            instr_done_d  = 1'b1;
            if (halt || halt_pend_q) state_d = ST_HALTED;
            else if (step_mode)      state_d = ST_IDLE;
          end else begin
            stage_idx_d = stage_idx_q + IDX_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_comb begin
    stage_en      = '0;
    busy          = 1'b0;
    halted        = 1'b0;
    stage_reset_n = 1'b1;
    case (state_q)
      ST_INIT:   stage_reset_n = 1'b0;
      ST_RUN: begin
        busy = 1'b1;
        if (!stall) stage_en = N_STAGES'(1) << stage_idx_q;
      end
      ST_HALTED: halted = 1'b1;
      default:   stage_reset_n = 1'b1;
    endcase
  end

  assign stage_idx   = stage_idx_q;
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (N_STAGES=9, CNT_W=32).
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stall, halt, step_mode;
  logic [8:0]  stage_en;
  logic [3:0]  stage_idx;
  logic        stage_reset_n, busy, halted, instr_done;
  logic [31:0] instr_count;

  int testsRun  = 0;
  int failCount = 0;

  stage_sequencer #(.N_STAGES(9), .CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .step_mode     (step_mode),
    .stage_en      (stage_en),
    .stage_idx     (stage_idx),
    .stage_reset_n (stage_reset_n),
    .busy          (busy),
    .halted        (halted),
    .instr_done    (instr_done),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive inputs just after a clock edge and let combinational outputs settle.
  task automatic applyStimulus(input logic s, input logic st, input logic h, input logic sm);
    start     = s;
    stall     = st;
    halt      = h;
    step_mode = sm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    int guard;

    // 1: reset, start, full instruction walk
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    tick(); tick();
    checkOutput("t1_init_srst", 32'(stage_reset_n), 32'd0);
    checkOutput("t1_init_en",   32'(stage_en), 32'd0);
    checkOutput("t1_init_cnt",  instr_count, 32'd0);
    checkOutput("t1_init_busy", 32'(busy), 32'd0);
    checkOutput("t1_init_hlt",  32'(halted), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("t1_idle_srst", 32'(stage_reset_n), 32'd1);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_idle_en",   32'(stage_en), 32'd0);
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("t1_en_%0d", k),  32'(stage_en), 32'd1 << k);
      checkOutput($sformatf("t1_idx_%0d", k), 32'(stage_idx), 32'(k));
      checkOutput($sformatf("t1_busy_%0d", k), 32'(busy), 32'd1);
      checkOutput($sformatf("t1_done_%0d", k), 32'(instr_done), 32'd0);
      tick();
    end
    checkOutput("t1_done",     32'(instr_done), 32'd1);
    checkOutput("t1_cnt",      instr_count, 32'd1);
    checkOutput("t1_cont_en",  32'(stage_en), 32'h001);
    checkOutput("t1_cont_idx", 32'(stage_idx), 32'd0);

    // 2: stall three cycles at stage 5; instruction takes 12 cycles
    n = 1;
    tick(); n++;
    checkOutput("t2_done_clr", 32'(instr_done), 32'd0);
    repeat (4) begin tick(); n++; end
    checkOutput("t2_idx5", 32'(stage_idx), 32'd5);
    applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t2_stall_en_%0d", k),  32'(stage_en), 32'd0);
      checkOutput($sformatf("t2_stall_idx_%0d", k), 32'(stage_idx), 32'd5);
      tick(); n++;
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_release_en", 32'(stage_en), 32'h020);
    guard = 0;
    while (!stage_en[8] && guard < 20) begin
      tick(); n++; guard++;
    end
    checkOutput("t2_cycles", 32'(n), 32'd12);
    tick();
    checkOutput("t2_done", 32'(instr_done), 32'd1);
    checkOutput("t2_cnt",  instr_count, 32'd2);

    // 3: halt pulse at stage 2; instruction finishes then HALTED is sticky
    tick(); tick();
    checkOutput("t3_idx2", 32'(stage_idx), 32'd2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t3_en2", 32'(stage_en), 32'h004);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int k = 3; k < 9; k++) begin
      checkOutput($sformatf("t3_en_%0d", k), 32'(stage_en), 32'd1 << k);
      tick();
    end
    checkOutput("t3_halted", 32'(halted), 32'd1);
    checkOutput("t3_busy",   32'(busy), 32'd0);
    checkOutput("t3_cnt",    instr_count, 32'd3);
    checkOutput("t3_done",   32'(instr_done), 32'd1);
    checkOutput("t3_en0",    32'(stage_en), 32'd0);
    applyStimulus(1, 1, 0, 1);
    tick(); tick();
    checkOutput("t3_sticky_hlt", 32'(halted), 32'd1);
    checkOutput("t3_sticky_en",  32'(stage_en), 32'd0);
    checkOutput("t3_sticky_cnt", instr_count, 32'd3);
    applyStimulus(0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    checkOutput("t3_rst_srst", 32'(stage_reset_n), 32'd0);
    checkOutput("t3_rst_hlt",  32'(halted), 32'd0);
    checkOutput("t3_rst_cnt",  instr_count, 32'd0);
    reset_n = 1'b1;
    tick();

    // 4: single-step, two starts 20 cycles apart
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 1);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
        if (stage_en != 9'd0) begin
          pulses++;
          checkOutput($sformatf("t4_onehot_%0d_%0d", r, c), 32'($onehot(stage_en)), 32'd1);
        end
        tick();
      end
      checkOutput($sformatf("t4_pulses_%0d", r), 32'(pulses), 32'd9);
      checkOutput($sformatf("t4_busy_%0d", r),   32'(busy), 32'd0);
    end
    checkOutput("t4_cnt", instr_count, 32'd2);

    // 5: reset mid-instruction at stage 6
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (6) tick();
    checkOutput("t5_idx6", 32'(stage_idx), 32'd6);
    reset_n = 1'b0;
    tick();
    checkOutput("t5_srst", 32'(stage_reset_n), 32'd0);
    checkOutput("t5_en",   32'(stage_en), 32'd0);
    checkOutput("t5_cnt",  instr_count, 32'd0);
    checkOutput("t5_done", 32'(instr_done), 32'd0);
    checkOutput("t5_idx",  32'(stage_idx), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("t5_done2", 32'(instr_done), 32'd0);

    // 6: counter wrap from all-ones
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    #1;
    checkOutput("t6_preload", instr_count, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 1);
    pulses = 0;
    repeat (9) begin
      if (instr_done) pulses++;
      tick();
    end
    checkOutput("t6_wrap",     instr_count, 32'd0);
    checkOutput("t6_done",     32'(instr_done), 32'd1);
    checkOutput("t6_no_early", 32'(pulses), 32'd0);
    tick();
    checkOutput("t6_done_clr", 32'(instr_done), 32'd0);

    // start and halt together in IDLE: halt wins
    applyStimulus(1, 0, 1, 0);
    checkOutput("t6_sh_en", 32'(stage_en), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_sh_hlt",  32'(halted), 32'd1);
    checkOutput("t6_sh_busy", 32'(busy), 32'd0);
    checkOutput("t6_sh_en2",  32'(stage_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
